exe_mul_stage: RTL and testbench

EXE_MUL_STAGE -- requirements
Module: exe_mul_stage

---
 rtl/exe_mul_stage_pkg.sv | 32 +++
 rtl/exe_mul_stage_seq_mul.sv | 73 +++++++
 rtl/exe_mul_stage.sv | 245 ++++++++++++++++++++++++
 tb/tb_exe_mul_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/exe_mul_stage_pkg.sv
// Shared definitions for the execute stage: ALU command encodings, the
// multiply FSM state enum and the NZCV bit positions within the status word.
package exe_mul_stage_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  function automatic logic [3:0] pack_nzcv(input logic n, input logic z,
                                           input logic c, input logic v);
    return {n, z, c, v};
  endfunction

endpackage

// File: rtl/exe_mul_stage_seq_mul.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle.
// start loads the operands; done flags the cycle of the last iteration.
module exe_seq_mul #(
  parameter int DATA_W   = 32,
  parameter int MUL_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int ITER  = DATA_W / MUL_STEP;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  logic [DATA_W-1:0] mcand_r;
  logic [DATA_W-1:0] mplier_r;
  logic [DATA_W-1:0] acc_r;
  logic [DATA_W-1:0] pp_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              run_r;

  // Partial product of the multiplicand with the low MUL_STEP multiplier bits.
  always_comb begin
    pp_s = '0;
    for (int k = 0; k < MUL_STEP; k++) begin
      if (mplier_r[k]) begin
        pp_s = pp_s + (mcand_r << k);
      end else begin
        pp_s = pp_s;
      end
    end
  end

  // Iteration state; the multiplicand shifts left so the product stays truncated.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_r  <= '0;
      mplier_r <= '0;
      acc_r    <= '0;
      cnt_r    <= '0;
      run_r    <= 1'b0;
    end else if (abort) begin
      cnt_r <= '0;
      run_r <= 1'b0;
    end else if (start) begin
      mcand_r  <= a;
      mplier_r <= b;
      acc_r    <= '0;
      cnt_r    <= '0;
      run_r    <= 1'b1;
    end else if (run_r) begin
      acc_r    <= acc_r + pp_s;
      mcand_r  <= mcand_r << MUL_STEP;
      mplier_r <= mplier_r >> MUL_STEP;
      if (cnt_r == LAST) begin
        cnt_r <= '0;
        run_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign done    = run_r && (cnt_r == LAST);
  assign product = acc_r;

endmodule

// File: rtl/exe_mul_stage.sv
// Execute stage with registered EXE/MEM outputs and an optional iterative
// multiply (exe_cmd 1010) enabled by defining EXE_MUL_EN.
module exe_mul_stage
  import exe_mul_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MUL_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              b_in,
  input  logic              s_in,
  input  logic [3:0]        exe_cmd_in,
  input  logic [3:0]        sr_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] val_rn_in,
  input  logic [DATA_W-1:0] val2_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic [23:0]       imm24_in,
  input  logic [3:0]        dest_in,
  output logic              out_valid,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              b,
  output logic              s,
  output logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] val_rm,
  output logic [DATA_W-1:0] branch_addr,
  output logic [3:0]        dest,
  output logic [3:0]        status,
  output logic              busy
);

  logic [DATA_W-1:0] add_b_s;
  logic              add_cin_s;
  logic [DATA_W:0]   sum_s;
  logic [DATA_W-1:0] alu_s;
  logic              arith_s;
  logic              known_s;
  logic              c_s;
  logic              v_s;
  logic [3:0]        flags_s;
  logic [DATA_W-1:0] imm_ext_s;
  logic [DATA_W-1:0] br_s;

  logic is_mul_s;
  logic idle_s;
  logic mul_out_s;
  logic take_in_s;

  logic [DATA_W-1:0] prod_s;
  logic              cap_wb_r, cap_mr_r, cap_mw_r, cap_b_r, cap_s_r, cap_c_r, cap_v_r;
  logic [3:0]        cap_dest_r;
  logic [DATA_W-1:0] cap_rm_r;
  logic [DATA_W-1:0] cap_br_r;

  logic              nxt_valid_s, nxt_wb_s, nxt_mr_s, nxt_mw_s, nxt_b_s, nxt_s_s;
  logic [DATA_W-1:0] nxt_alu_s, nxt_rm_s, nxt_br_s;
  logic [3:0]        nxt_dest_s, nxt_status_s;

  if (DATA_W >= 24) begin : g_imm_wide
    assign imm_ext_s = {{(DATA_W - 24){imm24_in[23]}}, imm24_in};
  end else begin : g_imm_narrow
    assign imm_ext_s = imm24_in[DATA_W-1:0];
  end
  assign br_s = pc_in + (imm_ext_s << 2);

  // Single-cycle ALU; subtraction is rn + ~val2 + cin, so C means "no borrow".
  always_comb begin
    add_b_s   = val2_in;
    add_cin_s = 1'b0;
    case (exe_cmd_in)
      CMD_ADC: add_cin_s = sr_in[SR_C];
      CMD_SUB: begin
        add_b_s   = ~val2_in;
        add_cin_s = 1'b1;
      end
      CMD_SBC: begin
        add_b_s   = ~val2_in;
        add_cin_s = sr_in[SR_C];
      end
      default: add_cin_s = 1'b0;
    endcase
    sum_s   = {1'b0, val_rn_in} + {1'b0, add_b_s} + {{DATA_W{1'b0}}, add_cin_s};
    alu_s   = '0;
    arith_s = 1'b0;
    known_s = 1'b1;
    case (exe_cmd_in)
      CMD_MOV: alu_s = val2_in;
      CMD_MVN: alu_s = ~val2_in;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
        alu_s   = sum_s[DATA_W-1:0];
        arith_s = 1'b1;
      end
      CMD_AND: alu_s = val_rn_in & val2_in;
      CMD_ORR: alu_s = val_rn_in | val2_in;
      CMD_EOR: alu_s = val_rn_in ^ val2_in;
      default: known_s = 1'b0;
    endcase
    c_s     = arith_s ? sum_s[DATA_W] : sr_in[SR_C];
    v_s     = arith_s ? ((val_rn_in[DATA_W-1] == add_b_s[DATA_W-1]) &&
                         (sum_s[DATA_W-1] != val_rn_in[DATA_W-1])) : sr_in[SR_V];
    flags_s = known_s ? pack_nzcv(alu_s[DATA_W-1], alu_s == '0, c_s, v_s) : sr_in;
  end

`ifdef EXE_MUL_EN
  mul_state_t state_r, state_nxt_s;
  logic       accept_mul_s;
  logic       mul_done_s;

  assign is_mul_s     = (exe_cmd_in == CMD_MUL);
  assign idle_s       = (state_r == IDLE);
  assign accept_mul_s = in_valid && in_ready && !flush && is_mul_s;
  assign mul_out_s    = (state_r == DONE) && !flush && !freeze;
  assign busy         = !idle_s;

  exe_seq_mul #(.DATA_W(DATA_W), .MUL_STEP(MUL_STEP)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept_mul_s),
    .abort   (flush && !idle_s),
    .a       (val_rn_in),
    .b       (val2_in),
    .done    (mul_done_s),
    .product (prod_s)
  );

  // Multiply FSM next state; RUN ignores freeze, flush aborts from RUN/DONE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: state_nxt_s = accept_mul_s ? RUN : IDLE;
      RUN: begin
        if (flush) begin
          state_nxt_s = IDLE;
        end else if (mul_done_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: state_nxt_s = (flush || !freeze) ? IDLE : DONE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Multiply FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Bundle fields captured at MUL acceptance, replayed when the product is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      {cap_wb_r, cap_mr_r, cap_mw_r, cap_b_r, cap_s_r, cap_c_r, cap_v_r} <= 7'b0;
      cap_dest_r <= 4'b0;
      cap_rm_r   <= '0;
      cap_br_r   <= '0;
    end else if (accept_mul_s) begin
      {cap_wb_r, cap_mr_r, cap_mw_r, cap_b_r, cap_s_r} <=
        {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in};
      cap_c_r    <= sr_in[SR_C];
      cap_v_r    <= sr_in[SR_V];
      cap_dest_r <= dest_in;
      cap_rm_r   <= val_rm_in;
      cap_br_r   <= br_s;
    end
  end
`else
  assign is_mul_s  = 1'b0;
  assign idle_s    = 1'b1;
  assign mul_out_s = 1'b0;
  assign busy      = 1'b0;
  assign prod_s    = '0;
  assign {cap_wb_r, cap_mr_r, cap_mw_r, cap_b_r, cap_s_r, cap_c_r, cap_v_r} = 7'b0;
  assign cap_dest_r = 4'b0;
  assign cap_rm_r   = '0;
  assign cap_br_r   = '0;
`endif

  assign in_ready  = !freeze && idle_s;
  assign take_in_s = in_valid && in_ready && !flush && !is_mul_s;

  // Next output bundle: product, accepted single-cycle result, or an all-zero bubble.
  always_comb begin
    {nxt_valid_s, nxt_wb_s, nxt_mr_s, nxt_mw_s, nxt_b_s, nxt_s_s} = 6'b0;
    nxt_alu_s    = '0;
    nxt_rm_s     = '0;
    nxt_br_s     = '0;
    nxt_dest_s   = 4'b0;
    nxt_status_s = 4'b0;
    if (mul_out_s) begin
      {nxt_valid_s, nxt_wb_s, nxt_mr_s, nxt_mw_s, nxt_b_s, nxt_s_s} =
        {1'b1, cap_wb_r, cap_mr_r, cap_mw_r, cap_b_r, cap_s_r};
      nxt_alu_s    = prod_s;
      nxt_rm_s     = cap_rm_r;
      nxt_br_s     = cap_br_r;
      nxt_dest_s   = cap_dest_r;
      nxt_status_s = pack_nzcv(prod_s[DATA_W-1], prod_s == '0, cap_c_r, cap_v_r);
    end else if (take_in_s) begin
      {nxt_valid_s, nxt_wb_s, nxt_mr_s, nxt_mw_s, nxt_b_s, nxt_s_s} =
        {1'b1, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in};
      nxt_alu_s    = alu_s;
      nxt_rm_s     = val_rm_in;
      nxt_br_s     = br_s;
      nxt_dest_s   = dest_in;
      nxt_status_s = flags_s;
    end else begin
      nxt_valid_s = 1'b0;
    end
  end

  // EXE/MEM output register; flush overrides freeze and loads a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      {out_valid, wb_en, mem_r_en, mem_w_en, b, s} <= 6'b0;
      alu_res     <= '0;
      val_rm      <= '0;
      branch_addr <= '0;
      dest        <= 4'b0;
      status      <= 4'b0;
    end else if (flush || !freeze) begin
      {out_valid, wb_en, mem_r_en, mem_w_en, b, s} <=
        {nxt_valid_s, nxt_wb_s, nxt_mr_s, nxt_mw_s, nxt_b_s, nxt_s_s};
      alu_res     <= nxt_alu_s;
      val_rm      <= nxt_rm_s;
      branch_addr <= nxt_br_s;
      dest        <= nxt_dest_s;
      status      <= nxt_status_s;
    end
  end

endmodule

// File: tb/tb_exe_mul_stage.sv
// Directed bench for exe_mul_stage; the MUL scenarios build only with EXE_MUL_EN.
module tb_exe_mul_stage;
  import exe_mul_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, in_valid, in_ready;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in;
  logic [3:0]  exe_cmd_in, sr_in, dest_in;
  logic [31:0] pc_in, val_rn_in, val2_in, val_rm_in;
  logic [23:0] imm24_in;
  logic        out_valid, wb_en, mem_r_en, mem_w_en, b, s, busy;
  logic [31:0] alu_res, val_rm, branch_addr;
  logic [3:0]  dest, status;

  int vectors     = 0;
  int miscompares = 0;
  int n;

  exe_mul_stage #(.DATA_W(32), .MUL_STEP(1)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .b_in(b_in), .s_in(s_in), .exe_cmd_in(exe_cmd_in), .sr_in(sr_in),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val2_in(val2_in), .val_rm_in(val_rm_in),
    .imm24_in(imm24_in), .dest_in(dest_in),
    .out_valid(out_valid), .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .b(b), .s(s), .alu_res(alu_res), .val_rm(val_rm), .branch_addr(branch_addr),
    .dest(dest), .status(status), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] cmd, input logic [31:0] rn,
                       input logic [31:0] v2, input logic [3:0] sr);
    in_valid   = v;
    exe_cmd_in = cmd;
    val_rn_in  = rn;
    val2_in    = v2;
    sr_in      = sr;
  endtask

  task automatic chk_res(input string tag, input logic [31:0] res, input logic [3:0] st);
    chk({tag, "_res"}, alu_res, res);
    chk({tag, "_status"}, 32'(status), 32'(st));
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0;
    wb_en_in = 1'b1; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0; b_in = 1'b0; s_in = 1'b1;
    pc_in = 32'h0000_0100; imm24_in = 24'hFFFFFE; dest_in = 4'd5; val_rm_in = 32'hCAFE_0001;
    drive(1'b0, CMD_ADD, 32'd0, 32'd0, 4'b0000);
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_res", alu_res, 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    drive(1'b1, CMD_ADD, 32'h7FFF_FFFF, 32'd1, 4'b0000);
    tick();
    chk_res("add_ovf", 32'h8000_0000, 4'b1001);
    chk("add_wb", 32'(wb_en), 32'd1);
    chk("add_s", 32'(s), 32'd1);
    chk("add_dest", 32'(dest), 32'd5);
    chk("add_rm", val_rm, 32'hCAFE_0001);
    chk("branch_addr", branch_addr, 32'h0000_00F8);

    freeze = 1'b1;
    drive(1'b1, CMD_SUB, 32'd5, 32'd5, 4'b0000);
    tick();
    chk("frz_ready", 32'(in_ready), 32'd0);
    tick();
    chk_res("frz_hold", 32'h8000_0000, 4'b1001);
    freeze = 1'b0;
    tick();
    chk_res("sub_zero", 32'd0, 4'b0110);

    drive(1'b1, CMD_SUB, 32'd3, 32'd5, 4'b0000);         tick(); chk_res("sub_neg", 32'hFFFF_FFFE, 4'b1000);
    drive(1'b1, CMD_ADC, 32'hFFFF_FFFF, 32'd0, 4'b0010); tick(); chk_res("adc_cin", 32'd0, 4'b0110);
    drive(1'b1, CMD_SBC, 32'd10, 32'd3, 4'b0000);        tick(); chk_res("sbc_borrow", 32'd6, 4'b0010);
    drive(1'b1, CMD_AND, 32'hF0F0, 32'hFF00, 4'b0011);   tick(); chk_res("and_cv", 32'hF000, 4'b0011);
    drive(1'b1, CMD_ORR, 32'h8000_0000, 32'd1, 4'b0000); tick(); chk_res("orr", 32'h8000_0001, 4'b1000);
    drive(1'b1, CMD_EOR, 32'hAAAA_5555, 32'hAAAA_5555, 4'b1010); tick(); chk_res("eor_z", 32'd0, 4'b0110);
    drive(1'b1, CMD_MOV, 32'd0, 32'h1234, 4'b0000);      tick(); chk_res("mov", 32'h1234, 4'b0000);
    drive(1'b1, CMD_MVN, 32'd0, 32'd0, 4'b0001);         tick(); chk_res("mvn", 32'hFFFF_FFFF, 4'b1001);
    drive(1'b1, 4'b1111, 32'd5, 32'd5, 4'b1011);         tick(); chk_res("unused", 32'd0, 4'b1011);

    drive(1'b0, CMD_ADD, 32'd1, 32'd1, 4'b0000);
    tick();
    chk("novalid_valid", 32'(out_valid), 32'd0);
    chk("novalid_wb", 32'(wb_en), 32'd0);
    chk("novalid_s", 32'(s), 32'd0);

    drive(1'b1, CMD_ADD, 32'd1, 32'd1, 4'b0000);
    tick();
    chk_res("add_small", 32'd2, 4'b0000);
    flush = 1'b1;
    tick();
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_wb", 32'(wb_en), 32'd0);
    flush = 1'b0;
    tick();
    chk_res("refill", 32'd2, 4'b0000);
    flush = 1'b1; freeze = 1'b1;
    tick();
    chk("flush_over_freeze_valid", 32'(out_valid), 32'd0);
    chk("flush_over_freeze_wb", 32'(wb_en), 32'd0);
    flush = 1'b0; freeze = 1'b0;

`ifndef EXE_MUL_EN
    drive(1'b1, CMD_MUL, 32'd7, 32'd6, 4'b0110);
    tick();
    chk_res("mul_off", 32'd0, 4'b0110);
    chk("mul_off_busy", 32'(busy), 32'd0);
`else
    drive(1'b1, CMD_MUL, 32'd7, 32'd6, 4'b0011);
    tick();
    drive(1'b0, CMD_ADD, 32'd0, 32'd0, 4'b0000);
    chk("mul_start_busy", 32'(busy), 32'd1);
    chk("mul_start_ready", 32'(in_ready), 32'd0);
    chk("mul_start_valid", 32'(out_valid), 32'd0);
    n = 1;
    while (busy === 1'b1 && n < 60) begin
      tick();
      if (busy === 1'b1) n++;
    end
    chk("mul_busy_cycles", 32'(n), 32'd33);
    chk_res("mul_7x6", 32'd42, 4'b0011);
    chk("mul_wb", 32'(wb_en), 32'd1);
    chk("mul_dest", 32'(dest), 32'd5);

    drive(1'b1, CMD_MUL, 32'd3, 32'd5, 4'b0000);
    tick();
    drive(1'b0, CMD_ADD, 32'd0, 32'd0, 4'b0000);
    repeat (31) tick();
    freeze = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("done_frz_busy", 32'(busy), 32'd1);
      chk("done_frz_ready", 32'(in_ready), 32'd0);
      chk("done_frz_valid", 32'(out_valid), 32'd0);
      chk("done_frz_res", alu_res, 32'd0);
    end
    freeze = 1'b0;
    tick();
    chk_res("mul_3x5", 32'd15, 4'b0000);
    chk("mul_3x5_busy", 32'(busy), 32'd0);

    drive(1'b1, CMD_MUL, 32'd9, 32'd9, 4'b0000);
    tick();
    drive(1'b0, CMD_ADD, 32'd0, 32'd0, 4'b0000);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("run_flush_busy", 32'(busy), 32'd0);
    chk("run_flush_valid", 32'(out_valid), 32'd0);
    chk("run_flush_wb", 32'(wb_en), 32'd0);
    chk("run_flush_ready", 32'(in_ready), 32'd1);
    repeat (40) tick();
    chk("run_flush_noprod_valid", 32'(out_valid), 32'd0);
    chk("run_flush_noprod_res", alu_res, 32'd0);

    drive(1'b1, CMD_MUL, 32'd2, 32'd2, 4'b1111);
    tick();
    drive(1'b0, CMD_ADD, 32'd0, 32'd0, 4'b0000);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("run_rst_busy", 32'(busy), 32'd0);
    chk("run_rst_valid", 32'(out_valid), 32'd0);
    chk("run_rst_status", 32'(status), 32'd0);
    tick();
    chk("run_rst_ready", 32'(in_ready), 32'd1);
    repeat (40) tick();
    chk("run_rst_noprod", 32'(out_valid), 32'd0);
`endif

    drive(1'b1, CMD_ADD, 32'h7FFF_FFFF, 32'd1, 4'b0000);
    tick();
    chk_res("pre_rst", 32'h8000_0000, 4'b1001);
    rst = 1'b1;
    drive(1'b0, CMD_ADD, 32'd0, 32'd0, 4'b0000);
    tick();
    rst = 1'b0;
    chk("rst2_valid", 32'(out_valid), 32'd0);
    chk("rst2_res", alu_res, 32'd0);
    chk("rst2_status", 32'(status), 32'd0);
    chk("rst2_branch", branch_addr, 32'd0);
    chk("rst2_rm", val_rm, 32'd0);
    chk("rst2_dest", 32'(dest), 32'd0);
    chk("rst2_wb_s", 32'({wb_en, s}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
